// File: rtl/raybox_input_pkg.sv
// Shared definitions for the raybox input blocks: channel count, repeat FSM
// encoding and the counter-width helper used by the button conditioner.
package raybox_input_pkg;

   localparam int NUM_BUTTONS = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   // Width able to hold 0..n-1; a single-cycle count still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw active-low inputs in, conditioned level/pulse outputs back.
interface button_conditioner_if;
   import raybox_input_pkg::*;

   logic [NUM_BUTTONS-1:0] btn_n;
   logic [NUM_BUTTONS-1:0] btn_level;
   logic [NUM_BUTTONS-1:0] btn_press;
   logic [NUM_BUTTONS-1:0] btn_release;
   logic [NUM_BUTTONS-1:0] btn_repeat;

   modport master (
      input  btn_n,
      output btn_level, btn_press, btn_release, btn_repeat
   );

   modport slave (
      output btn_n,
      input  btn_level, btn_press, btn_release, btn_repeat
   );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, debouncer and auto-repeat FSM.
// All outputs come straight from flops.
module button_channel
   import raybox_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_PERIOD   = 2500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat
);

   localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

   localparam logic [DEB_W-1:0] DEB_TC    = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_TC  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_TC = RPT_W'(REPEAT_PERIOD - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             deb_level;
   logic [DEB_W-1:0] deb_cnt;
   logic [RPT_W-1:0] rpt_cnt;
   rpt_state_e       state;
   logic             press_evt;
   logic             release_evt;

   // deb_level leads btn_level by one cycle, so their difference is the edge event.
   assign press_evt   =  deb_level & ~btn_level;
   assign release_evt = ~deb_level &  btn_level;

   // Inversion happens on the way into the first flop so the reset value means "not held".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1     <= 1'b0;
         sync_q2     <= 1'b0;
         deb_level   <= 1'b0;
         deb_cnt     <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
         // synchronizer really is two stages regardless of statement order.
         sync_q1 <= ~btn_n;
         sync_q2 <= sync_q1;
         if (sync_q2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_TC) begin
            deb_level <= ~deb_level;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
         btn_level   <= deb_level;
         btn_press   <= press_evt;
         btn_release <= release_evt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rpt_cnt    <= '0;
         btn_repeat <= 1'b0;
      end else begin
         btn_repeat <= 1'b0;
         // Release wins over a terminal count landing on the same edge.
         if (release_evt) begin
            state   <= IDLE;
            rpt_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (press_evt) begin
                     state   <= DELAY;
                     rpt_cnt <= '0;
                  end
               end
               DELAY: begin
                  if (rpt_cnt == DELAY_TC) begin
                     state      <= REPEAT;
                     rpt_cnt    <= '0;
                     btn_repeat <= 1'b1;
                  end else begin
                     rpt_cnt <= rpt_cnt + RPT_W'(1);
                  end
               end
               REPEAT: begin
                  if (rpt_cnt == PERIOD_TC) begin
                     rpt_cnt    <= '0;
                     btn_repeat <= 1'b1;
                  end else begin
                     rpt_cnt <= rpt_cnt + RPT_W'(1);
                  end
               end
               default: begin
                  state   <= IDLE;
                  rpt_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw K4..K1 buttons: one independent channel per button,
// no cross-channel logic.
module button_conditioner
   import raybox_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_PERIOD   = 2500000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   button_conditioner_if.master bus
);

   logic [NUM_BUTTONS-1:0] level_w;
   logic [NUM_BUTTONS-1:0] press_w;
   logic [NUM_BUTTONS-1:0] release_w;
   logic [NUM_BUTTONS-1:0] repeat_w;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .btn_n       (bus.btn_n[i]),
         .btn_level   (level_w[i]),
         .btn_press   (press_w[i]),
         .btn_release (release_w[i]),
         .btn_repeat  (repeat_w[i])
      );
   end

   assign bus.btn_level   = level_w;
   assign bus.btn_press   = press_w;
   assign bus.btn_release = release_w;
   assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat parameters.
// Outputs are compared as one 16-bit {level, press, release, repeat} vector per edge.
module tb_button_conditioner;
   import raybox_input_pkg::*;

   localparam int DEB = 4;
   localparam int RD  = 8;
   localparam int RP  = 3;
   localparam int LAT = DEB + 2;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Edge at which each button is first sampled low / sampled high again.
   int   s_edge [NUM_BUTTONS];
   int   r_edge [NUM_BUTTONS];

   button_conditioner_if bif ();

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] expect_vec(input int k);
      logic [3:0] lv, pr, rl, rp;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         int s, e;
         s = s_edge[i] + LAT;
         e = r_edge[i] + LAT;
         lv[i] = (k >= s) && (k < e);
         pr[i] = (k == s);
         rl[i] = (k == e);
         rp[i] = (k >= s + RD) && (k < e) && (((k - s - RD) % RP) == 0);
      end
      return {lv, pr, rl, rp};
   endfunction

   function automatic logic [15:0] observed();
      return {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat};
   endfunction

   task automatic clear_edges();
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         s_edge[i] = NEVER;
         r_edge[i] = 2 * NEVER;
      end
   endtask

   task automatic drive_for(input int k);
      for (int i = 0; i < NUM_BUTTONS; i++)
         bif.btn_n[i] = !((k >= s_edge[i]) && (k < r_edge[i]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      bif.btn_n = 4'hF;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      reset_n   = 1'b0;
      bif.btn_n = 4'hF;
      repeat (2) @(posedge clk);
      #1 got = observed();
      checks++;
      if (got !== 16'h0000) begin
         failures++;
         $display("FAIL reset_idle got=%h expected=%h", got, 16'h0000);
      end
      bif.btn_n = 4'h0;
      repeat (8) @(posedge clk);
      #1 got = observed();
      checks++;
      if (got !== 16'h0000) begin
         failures++;
         $display("FAIL reset_held_buttons got=%h expected=%h", got, 16'h0000);
      end
      do_reset();
   endtask

   task automatic test_press();
      logic [15:0] got, exp;
      clear_edges();
      s_edge[0] = 0;
      r_edge[0] = 17;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         drive_for(k);
         @(posedge clk);
         #1 got = observed();
         exp = expect_vec(k);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL press edge=%0d got=%h expected=%h", k, got, exp);
         end
      end
   endtask

   // Continues test_press: release sampled at edge 17 lands on the repeat terminal count at 23.
   task automatic test_release_priority();
      logic [15:0] got, exp;
      for (int k = 17; k <= 32; k++) begin
         @(negedge clk);
         drive_for(k);
         @(posedge clk);
         #1 got = observed();
         exp = expect_vec(k);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL release_priority edge=%0d got=%h expected=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_glitch();
      logic [15:0] got;
      do_reset();
      for (int k = 0; k <= 14; k++) begin
         @(negedge clk);
         bif.btn_n = (k < DEB - 1) ? 4'b1101 : 4'b1111;
         @(posedge clk);
         #1 got = observed();
         checks++;
         if (got !== 16'h0000) begin
            failures++;
            $display("FAIL glitch edge=%0d got=%h expected=%h", k, got, 16'h0000);
         end
      end
   endtask

   task automatic test_held_through_reset();
      logic [15:0] got, exp;
      @(negedge clk);
      reset_n   = 1'b0;
      bif.btn_n = 4'b0111;
      repeat (2) @(negedge clk);
      clear_edges();
      s_edge[3] = 0;
      reset_n   = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         @(posedge clk);
         #1 got = observed();
         exp = expect_vec(k);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL held_reset edge=%0d got=%h expected=%h", k, got, exp);
         end
      end
   endtask

   // Button 3 is still held and its FSM is in REPEAT from the previous task.
   task automatic test_reset_mid_repeat();
      logic [15:0] got, exp;
      @(negedge clk);
      reset_n = 1'b0;
      #1 got = observed();
      checks++;
      if (got !== 16'h0000) begin
         failures++;
         $display("FAIL reset_async got=%h expected=%h", got, 16'h0000);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1 got = observed();
         checks++;
         if (got !== 16'h0000) begin
            failures++;
            $display("FAIL reset_hold cycle=%0d got=%h expected=%h", c, got, 16'h0000);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(posedge clk);
         #1 got = observed();
         exp = expect_vec(k);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_mid_repeat edge=%0d got=%h expected=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_independence();
      logic [15:0] got, exp;
      do_reset();
      clear_edges();
      s_edge[0] = 0;  r_edge[0] = 2 * NEVER;
      s_edge[1] = 1;  r_edge[1] = 10;
      s_edge[2] = 2;  r_edge[2] = 2 * NEVER;
      s_edge[3] = 3;  r_edge[3] = 25;
      for (int k = 0; k <= 35; k++) begin
         @(negedge clk);
         drive_for(k);
         @(posedge clk);
         #1 got = observed();
         exp = expect_vec(k);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL independence edge=%0d got=%h expected=%h", k, got, exp);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bif.btn_n = 4'hF;
      clear_edges();
      test_reset();
      test_press();
      test_release_priority();
      test_glitch();
      test_held_through_reset();
      test_reset_mid_repeat();
      test_independence();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
